fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 imem_req  out  1  SHALL mark an instruction memory read request pending.
REQ-005 imem_addr  out  32  SHALL carry the word-aligned fetch address.
REQ-006 imem_ack  in  1  SHALL be a one-cycle pulse completing the pending request.
REQ-007 imem_rdata  in  32  SHALL carry the instruction word, valid only when imem_ack=1.
REQ-008 stall  in  1  SHALL be the hazard hold request from decode.
REQ-009 jump  in  1  SHALL be the decode-stage jump control (muxctrl bit 7).
REQ-010 jump_index  in  26  SHALL be the J-type target index.
REQ-011 branch  in  1  SHALL be the decode-stage branch control (muxctrl bit 9).
REQ-012 zero  in  1  SHALL be the ALU zero flag for the branch compare.
REQ-013 branch_imm  in  16  SHALL be the branch offset in words, signed.
REQ-014 id_instr  out  32  SHALL be the IF/ID instruction register.
REQ-015 op, func  out  6 each  SHALL equal id_instr[31:26] and id_instr[5:0], feeding the controller.
REQ-016 id_pc  out  32  SHALL be the address of id_instr.
REQ-017 id_valid  out  1  SHALL mark id_instr as a real instruction rather than a bubble.

Function
REQ-018 State SHALL be one of FETCH, HOLD or DRAIN; imem_req SHALL be 1 in FETCH and DRAIN and 0 in HOLD.
REQ-019 imem_addr SHALL equal pc in FETCH; in DRAIN it SHALL equal the abandoned address (drain_addr).
REQ-020 imem_addr SHALL stay stable while imem_req=1 and no ack has arrived.
REQ-021 redirect SHALL equal jump | (branch & zero); jump SHALL win when both are set.
REQ-022 Jump target SHALL be {id_pc_plus4[31:28], jump_index, 2'b00}, where id_pc_plus4 = id_pc + 4 mod 2^32.
REQ-023 Branch target SHALL be id_pc_plus4 + (sign-extended branch_imm << 2), modulo 2^32.
REQ-024 Redirect SHALL take priority over stall and ack in every state, and SHALL:
- set pc to the target;
- load bubble id_instr=0, id_valid=0, with id_pc unchanged;
- discard any skid word.
REQ-025 Redirect next state:
- FETCH without ack in the same cycle -> DRAIN, with drain_addr = old pc;
- FETCH with ack, or HOLD -> FETCH;
- DRAIN -> remain DRAIN.
REQ-026 FETCH, ack=1, stall=0, no redirect: load id_instr=imem_rdata, id_pc=pc, id_valid=1, pc+=4; stay FETCH.
REQ-027 FETCH, ack=1, stall=1, no redirect: capture {imem_rdata, pc} in skid; pc+=4; IF/ID holds; go HOLD.
REQ-028 FETCH, ack=0, no redirect: if stall=1, IF/ID holds; otherwise load bubble (id_instr=0, id_valid=0).
REQ-029 HOLD, stall=1, no redirect: everything holds.
REQ-030 HOLD, stall=0, no redirect: load IF/ID from skid with id_valid=1; go FETCH.
REQ-031 DRAIN: the returning word SHALL be dropped on ack; then go FETCH at pc.
REQ-032 DRAIN, stall=0: IF/ID SHALL load bubbles.
REQ-033 pc SHALL wrap from 32'hFFFF_FFFC to 0.

Reset
REQ-034 While reset_n=0, the block SHALL hold:
- pc=RESET_PC, state=FETCH, imem_req=0;
- id_instr=0, id_pc=0, id_valid=0;
- skid cleared.
REQ-035 imem_req SHALL assert with imem_addr=RESET_PC in the first cycle after reset_n rises.
REQ-036 Reset asserted mid-request SHALL abandon the request; a late ack SHALL be ignored in that cycle.

Verification
REQ-037 Sequential fetch: ack every cycle with words A, B, C.
- Required: id_instr=A/B/C with id_pc=0/4/8 on successive cycles, id_valid=1 throughout.
REQ-038 Stall on ack: stall=1 for 3 cycles while word B (pc=4) is acked.
- Required: state=HOLD and imem_req=0 during the stall; id_instr=A held.
- Required: B appears with id_pc=4 the cycle stall drops; the next fetch is at 8.
REQ-039 Taken branch with pending request: id_pc=0x10, branch=1, zero=1, branch_imm=16'hFFFC, ack delayed 2 cycles.
- Required: DRAIN with imem_addr held; the late word is discarded.
- Required: the next request is at 0x04; exactly one bubble (id_valid=0).
REQ-040 Jump beats branch: id_pc=0x1000_0000, jump=1, jump_index=26'h40, branch=1, zero=1.
- Required: the next fetch is at 0x1000_0100.
REQ-041 Redirect in HOLD with stall=1: skid is discarded, the next request is at the target, id_valid=0.
REQ-042 Async reset asserted mid-DRAIN:
- Required: outputs reach their reset values immediately, without waiting for a clock edge.
- Required: the first request after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the program counter, talks to instruction
// memory and fills the IF/ID register. A skid register holds a word that
// came back while decode stalled. A drain state waits out a request that
// a redirect abandoned, so its late word never reaches decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch,
  input  logic        zero,
  input  logic [15:0] branch_imm,
  output logic [31:0] id_instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] id_pc,
  output logic        id_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        redirect;
  logic [31:0] id_pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] target;

  // Redirect target from the decode-stage instruction; jump outranks branch
  always_comb begin
    id_pc_plus4 = id_pc + 32'd4;
    branch_off  = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    redirect    = jump | (branch & zero);
    if (jump) begin
      target = {id_pc_plus4[31:28], jump_index, 2'b00};
    end else begin
      target = id_pc_plus4 + branch_off;
    end
  end

  // During reset the request drops at once; otherwise only HOLD idles memory
  assign imem_req  = reset_n & (state != HOLD);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign op        = id_instr[31:26];
  assign func      = id_instr[5:0];

  // Fetch state machine, program counter, skid and IF/ID register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= 32'd0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      id_instr   <= 32'd0;
      id_pc      <= 32'd0;
      id_valid   <= 1'b0;
    end else if (redirect) begin
      pc         <= target;
      id_instr   <= 32'd0;
      id_valid   <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      if (state == FETCH && !imem_ack) begin
        state      <= DRAIN;
        drain_addr <= pc;
      end else if (state != DRAIN) begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            pc <= pc + 32'd4;
            if (stall) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= HOLD;
            end else begin
              id_instr <= imem_rdata;
              id_pc    <= pc;
              id_valid <= 1'b1;
            end
          end else if (!stall) begin
            id_instr <= 32'd0;
            id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_instr <= skid_instr;
            id_pc    <= skid_pc;
            id_valid <= 1'b1;
            state    <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state <= FETCH;
          end
          if (!stall) begin
            id_instr <= 32'd0;
            id_valid <= 1'b0;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with fixed expected
// values, then randomized traffic compared against a behavioural model.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch;
  logic        zero;
  logic [15:0] branch_imm;
  logic [31:0] id_instr;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] id_pc;
  logic        id_valid;

  int nTests = 0;
  int nFail  = 0;

  localparam int M_FETCH = 0;
  localparam int M_HOLD  = 1;
  localparam int M_DRAIN = 2;

  int          mState;
  logic [31:0] mPc;
  logic [31:0] mDrain;
  logic [31:0] mInstr;
  logic [31:0] mIdPc;
  logic        mValid;
  logic [63:0] skidQ[$];

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .jump(jump), .jump_index(jump_index),
    .branch(branch), .zero(zero), .branch_imm(branch_imm),
    .id_instr(id_instr), .op(op), .func(func),
    .id_pc(id_pc), .id_valid(id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mState = M_FETCH;
    mPc    = 32'h0;
    mDrain = 32'h0;
    mInstr = 32'h0;
    mIdPc  = 32'h0;
    mValid = 1'b0;
    skidQ.delete();
  endtask

  // Next-cycle behaviour written from the fetch rules, one clock at a time
  task automatic modelStep();
    logic [31:0] plus4;
    logic [31:0] tgt;
    int          off;
    logic [63:0] s;
    if (!reset_n) begin
      modelReset();
      return;
    end
    plus4 = mIdPc + 32'd4;
    off   = int'($signed(branch_imm));
    if (jump) tgt = (plus4 & 32'hF000_0000) | (32'(jump_index) * 32'd4);
    else      tgt = plus4 + 32'(off * 4);
    if (jump || (branch && zero)) begin
      if (mState == M_FETCH && !imem_ack) begin
        mDrain = mPc;
        mState = M_DRAIN;
      end else if (mState == M_HOLD) begin
        mState = M_FETCH;
      end
      mPc = tgt;
      mInstr = 32'h0;
      mValid = 1'b0;
      skidQ.delete();
    end else if (mState == M_FETCH) begin
      if (imem_ack) begin
        if (stall) begin
          skidQ.push_back({imem_rdata, mPc});
          mState = M_HOLD;
        end else begin
          mInstr = imem_rdata;
          mIdPc  = mPc;
          mValid = 1'b1;
        end
        mPc = mPc + 32'd4;
      end else if (!stall) begin
        mInstr = 32'h0;
        mValid = 1'b0;
      end
    end else if (mState == M_HOLD) begin
      if (!stall) begin
        s = skidQ.pop_front();
        mInstr = s[63:32];
        mIdPc  = s[31:0];
        mValid = 1'b1;
        mState = M_FETCH;
      end
    end else begin
      if (imem_ack) mState = M_FETCH;
      if (!stall) begin
        mInstr = 32'h0;
        mValid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [31:0] d, input logic s);
    imem_ack   = a;
    imem_rdata = d;
    stall      = s;
  endtask

  task automatic clearCtl();
    jump = 1'b0; jump_index = 26'h0; branch = 1'b0; zero = 1'b0; branch_imm = 16'h0;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    clearCtl();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    clearCtl();
    modelReset();
    #3;
    nTests++; if (imem_req !== 1'b0) begin nFail++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
    nTests++; if (id_instr !== 32'h0) begin nFail++; $display("[TB] FAIL reset_instr: got %h want 0", id_instr); end
    nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %b want 0", id_valid); end
    nTests++; if (id_pc !== 32'h0) begin nFail++; $display("[TB] FAIL reset_idpc: got %h want 0", id_pc); end
    @(posedge clk); #1;
    nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ack_ignored: got %b want 0", id_valid); end
    imem_ack = 1'b0;
    reset_n  = 1'b1;
    #1;
    nTests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin nFail++; $display("[TB] FAIL reset_first_req: req %b addr %h want 1 00000000", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words = '{32'h2108_0001, 32'h8C42_0004, 32'hAC63_0008};
    applyReset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, words[i], 1'b0);
      tick();
      nTests++; if (id_instr !== words[i] || id_pc !== 32'(i * 4) || id_valid !== 1'b1) begin
        nFail++; $display("[TB] FAIL seq_%0d: got %h@%h v%b want %h@%h v1", i, id_instr, id_pc, id_valid, words[i], 32'(i * 4));
      end
    end
    nTests++; if (op !== words[2][31:26] || func !== words[2][5:0]) begin nFail++; $display("[TB] FAIL seq_opfunc: got %h/%h want %h/%h", op, func, words[2][31:26], words[2][5:0]); end
  endtask

  task automatic test_stall();
    applyReset();
    drive(1'b1, 32'hAAAA_0001, 1'b0); tick();
    drive(1'b1, 32'hBBBB_0002, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      nTests++; if (imem_req !== 1'b0 || id_instr !== 32'hAAAA_0001) begin
        nFail++; $display("[TB] FAIL stall_hold_%0d: req %b instr %h want 0 aaaa0001", i, imem_req, id_instr);
      end
      if (i < 2) begin drive(1'b0, 32'h0, 1'b1); tick(); end
    end
    drive(1'b0, 32'h0, 1'b0); tick();
    nTests++; if (id_instr !== 32'hBBBB_0002 || id_pc !== 32'h4 || id_valid !== 1'b1) begin nFail++; $display("[TB] FAIL stall_release: got %h@%h v%b want bbbb0002@4 v1", id_instr, id_pc, id_valid); end
    nTests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin nFail++; $display("[TB] FAIL stall_next: req %b addr %h want 1 8", imem_req, imem_addr); end
  endtask

  task automatic test_branch();
    applyReset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 32'h100 + 32'(i), 1'b0); tick(); end
    nTests++; if (id_pc !== 32'h10) begin nFail++; $display("[TB] FAIL br_setup: got %h want 10", id_pc); end
    branch = 1'b1; zero = 1'b1; branch_imm = 16'hFFFC;
    drive(1'b0, 32'h0, 1'b0); tick();
    clearCtl();
    nTests++; if (imem_req !== 1'b1 || imem_addr !== 32'h14 || id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL br_drain: req %b addr %h v%b want 1 14 v0", imem_req, imem_addr, id_valid); end
    drive(1'b0, 32'h0, 1'b0); tick();
    nTests++; if (imem_addr !== 32'h14) begin nFail++; $display("[TB] FAIL br_addr_held: got %h want 14", imem_addr); end
    drive(1'b1, 32'hDEAD_BEEF, 1'b0); tick();
    nTests++; if (imem_addr !== 32'h4 || id_instr !== 32'h0 || id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL br_drop: addr %h instr %h v%b want 4 0 v0", imem_addr, id_instr, id_valid); end
    drive(1'b1, 32'h0000_1234, 1'b0); tick();
    nTests++; if (id_instr !== 32'h0000_1234 || id_pc !== 32'h4 || id_valid !== 1'b1) begin nFail++; $display("[TB] FAIL br_target_word: got %h@%h v%b want 1234@4 v1", id_instr, id_pc, id_valid); end
  endtask

  task automatic test_jump();
    applyReset();
    jump = 1'b1; jump_index = 26'h3FF_FFFF;
    drive(1'b0, 32'h0, 1'b0); tick();
    clearCtl();
    drive(1'b1, 32'h0, 1'b0); tick();
    nTests++; if (imem_addr !== 32'h0FFF_FFFC) begin nFail++; $display("[TB] FAIL jmp_far: got %h want 0ffffffc", imem_addr); end
    drive(1'b1, 32'h1111_1111, 1'b0); tick();
    drive(1'b1, 32'h2222_2222, 1'b0); tick();
    nTests++; if (id_pc !== 32'h1000_0000) begin nFail++; $display("[TB] FAIL jmp_setup: got %h want 10000000", id_pc); end
    jump = 1'b1; jump_index = 26'h40; branch = 1'b1; zero = 1'b1; branch_imm = 16'h0001;
    drive(1'b0, 32'h0, 1'b0); tick();
    clearCtl();
    drive(1'b1, 32'h0, 1'b0); tick();
    nTests++; if (imem_addr !== 32'h1000_0100 || imem_req !== 1'b1) begin nFail++; $display("[TB] FAIL jmp_wins: req %b addr %h want 1 10000100", imem_req, imem_addr); end
  endtask

  task automatic test_hold_redirect();
    applyReset();
    drive(1'b1, 32'hAAAA_0001, 1'b0); tick();
    drive(1'b1, 32'hBBBB_0002, 1'b1); tick();
    jump = 1'b1; jump_index = 26'h20;
    drive(1'b0, 32'h0, 1'b1); tick();
    clearCtl();
    nTests++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || id_valid !== 1'b0 || id_instr !== 32'h0) begin nFail++; $display("[TB] FAIL hold_redir: req %b addr %h instr %h v%b want 1 80 0 v0", imem_req, imem_addr, id_instr, id_valid); end
    drive(1'b0, 32'h0, 1'b0); tick();
    nTests++; if (id_valid !== 1'b0 || imem_addr !== 32'h80) begin nFail++; $display("[TB] FAIL hold_skid_gone: v%b addr %h want v0 80", id_valid, imem_addr); end
    drive(1'b1, 32'hCCCC_0003, 1'b0); tick();
    nTests++; if (id_instr !== 32'hCCCC_0003 || id_pc !== 32'h80) begin nFail++; $display("[TB] FAIL hold_target_word: got %h@%h want cccc0003@80", id_instr, id_pc); end
  endtask

  task automatic test_wrap();
    applyReset();
    drive(1'b1, 32'h0A0A_0A0A, 1'b0); tick();
    branch = 1'b1; zero = 1'b1; branch_imm = 16'hFFFE;
    drive(1'b1, 32'h0B0B_0B0B, 1'b0); tick();
    clearCtl();
    nTests++; if (imem_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL wrap_target: addr %h v%b want fffffffc v0", imem_addr, id_valid); end
    drive(1'b1, 32'h0C0C_0C0C, 1'b0); tick();
    nTests++; if (id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin nFail++; $display("[TB] FAIL wrap_pc: idpc %h addr %h want fffffffc 0", id_pc, imem_addr); end
  endtask

  task automatic test_async_reset();
    applyReset();
    drive(1'b1, 32'h1357_9BDF, 1'b0); tick();
    branch = 1'b1; zero = 1'b1; branch_imm = 16'h0004;
    drive(1'b0, 32'h0, 1'b0); tick();
    clearCtl();
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    nTests++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0) begin nFail++; $display("[TB] FAIL areset_immediate: req %b v%b instr %h idpc %h want 0 0 0 0", imem_req, id_valid, id_instr, id_pc); end
    drive(1'b1, 32'h7777_7777, 1'b0); tick();
    nTests++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin nFail++; $display("[TB] FAIL areset_late_ack: instr %h v%b want 0 v0", id_instr, id_valid); end
    drive(1'b0, 32'h0, 1'b0);
    reset_n = 1'b1;
    #1;
    nTests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin nFail++; $display("[TB] FAIL areset_release: req %b addr %h want 1 0", imem_req, imem_addr); end
    drive(1'b1, 32'h2468_ACE0, 1'b0); tick();
    nTests++; if (id_instr !== 32'h2468_ACE0 || id_pc !== 32'h0) begin nFail++; $display("[TB] FAIL areset_first_word: got %h@%h want 2468ace0@0", id_instr, id_pc); end
  endtask

  task automatic test_random();
    logic        expReq;
    logic [31:0] expAddr;
    int          bad;
    applyReset();
    for (int c = 0; c < 400; c++) begin
      expReq     = (mState != M_HOLD);
      stall      = ($urandom % 4) == 0;
      imem_ack   = expReq && (($urandom % 2) == 0);
      imem_rdata = $urandom;
      jump       = ($urandom % 12) == 0;
      jump_index = 26'($urandom);
      branch     = ($urandom % 8) == 0;
      zero       = ($urandom % 2) == 0;
      branch_imm = 16'($urandom);
      tick();
      expReq  = (mState != M_HOLD);
      expAddr = (mState == M_DRAIN) ? mDrain : mPc;
      bad = 0;
      nTests++;
      if (imem_req !== expReq) bad = 1;
      if (expReq && imem_addr !== expAddr) bad = 1;
      if (id_instr !== mInstr || id_pc !== mIdPc || id_valid !== mValid) bad = 1;
      if (op !== mInstr[31:26] || func !== mInstr[5:0]) bad = 1;
      if (bad != 0) begin
        nFail++;
        $display("[TB] FAIL rand_%0d: req %b addr %h instr %h@%h v%b want %b %h %h@%h v%b", c, imem_req, imem_addr, id_instr, id_pc, id_valid, expReq, expAddr, mInstr, mIdPc, mValid);
      end
    end
    clearCtl();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    clearCtl();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_hold_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
